// File: rtl/mbist_pkg.sv
// Shared types and defaults for the MBIST Wishbone arbiter slice.
package mbist_pkg;

    localparam int BIST_ADDR_WD_DEF = 10;
    localparam int BIST_DATA_WD_DEF = 32;
    localparam int BIST_SEL_WD_DEF  = BIST_DATA_WD_DEF / 8;
    localparam int TMO_CYC_DEF      = 16;

    // Arbiter ownership of the shared slave port.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT0 = 2'd1,
        ST_GNT1 = 2'd2
    } arb_state_e;

    // One master's request bundle at the default bus geometry.
    typedef struct packed {
        logic                        cyc;
        logic                        stb;
        logic                        we;
        logic [BIST_ADDR_WD_DEF-1:0] adr;
        logic [BIST_DATA_WD_DEF-1:0] dat;
        logic [BIST_SEL_WD_DEF-1:0]  sel;
    } wb_req_t;

endpackage

// File: rtl/mbist_wb_tmo.sv
// Per-access timeout: counts stalled strobe cycles and flags the cycle in
// which a hung slave must be answered with an error instead.
module mbist_wb_tmo
    import mbist_pkg::*;
#(
    parameter int TMO_CYC = TMO_CYC_DEF
) (
    input  logic wb_clk_i,
    input  logic rst_n,
    input  logic stb_i,      // granted master's strobe, before masking
    input  logic ack_i,
    input  logic err_i,
    input  logic clr_i,      // arbiter state is changing this cycle
    output logic tmo_hit_o
);

    localparam int                CNT_W    = $clog2(TMO_CYC);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TMO_CYC - 1);

    logic [CNT_W-1:0] tmo_cnt_q;
    logic [CNT_W-1:0] tmo_cnt_d;
    logic             hit_s;

    // An ack arriving on the threshold cycle wins over the timeout.
    assign hit_s     = stb_i & ~ack_i & (tmo_cnt_q == CNT_LAST);
    assign tmo_hit_o = hit_s;

    // Count only while the (masked) strobe waits; any other cycle restarts.
    always_comb begin
        tmo_cnt_d = {CNT_W{1'b0}};
        if (clr_i) begin
            tmo_cnt_d = {CNT_W{1'b0}};
        end else if (stb_i & ~hit_s & ~ack_i & ~err_i) begin
            tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
        end else begin
            tmo_cnt_d = {CNT_W{1'b0}};
        end
    end

    // Counter register.
    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q <= {CNT_W{1'b0}};
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

endmodule

// File: rtl/mbist_wb_arb.sv
// Two-master Wishbone arbiter in front of the MBIST memory wrapper.
// Master 0 is the functional host, master 1 the MBIST controller. The grant
// is registered and held for the whole cyc; bist_en restricts new grants to
// master 1. A hung slave is answered with a one-cycle error.
module mbist_wb_arb
    import mbist_pkg::*;
#(
    parameter int BIST_ADDR_WD = BIST_ADDR_WD_DEF,
    parameter int BIST_DATA_WD = BIST_DATA_WD_DEF,
    parameter int TMO_CYC      = TMO_CYC_DEF
) (
    input  logic                      wb_clk_i,
    input  logic                      rst_n,
    input  logic                      bist_en,
    input  logic                      m0_cyc_i,
    input  logic                      m0_stb_i,
    input  logic                      m0_we_i,
    input  logic [BIST_ADDR_WD-1:0]   m0_adr_i,
    input  logic [BIST_DATA_WD-1:0]   m0_dat_i,
    input  logic [BIST_DATA_WD/8-1:0] m0_sel_i,
    output logic [BIST_DATA_WD-1:0]   m0_dat_o,
    output logic                      m0_ack_o,
    output logic                      m0_err_o,
    input  logic                      m1_cyc_i,
    input  logic                      m1_stb_i,
    input  logic                      m1_we_i,
    input  logic [BIST_ADDR_WD-1:0]   m1_adr_i,
    input  logic [BIST_DATA_WD-1:0]   m1_dat_i,
    input  logic [BIST_DATA_WD/8-1:0] m1_sel_i,
    output logic [BIST_DATA_WD-1:0]   m1_dat_o,
    output logic                      m1_ack_o,
    output logic                      m1_err_o,
    output logic                      s_cyc_o,
    output logic                      s_stb_o,
    output logic                      s_we_o,
    output logic [BIST_ADDR_WD-1:0]   s_adr_o,
    output logic [BIST_DATA_WD-1:0]   s_dat_o,
    output logic [BIST_DATA_WD/8-1:0] s_sel_o,
    input  logic [BIST_DATA_WD-1:0]   s_dat_i,
    input  logic                      s_ack_i,
    input  logic                      s_err_i
);

    localparam int SEL_WD = BIST_DATA_WD / 8;

    arb_state_e state_q;
    arb_state_e state_d;
    logic       last_gnt_q;   // 1 = master 1 was granted most recently
    logic       last_gnt_d;
    logic       gnt0_s;
    logic       gnt1_s;
    logic       stb_raw_s;
    logic       tmo_hit_s;
    logic       state_chg_s;

    // Arbitration: only IDLE makes a decision, so each cyc pays one idle cycle.
    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        case (state_q)
            ST_IDLE: begin
                if (bist_en) begin
                    if (m1_cyc_i) begin
                        state_d    = ST_GNT1;
                        last_gnt_d = 1'b1;
                    end else begin
                        state_d    = ST_IDLE;
                    end
                end else if (m0_cyc_i && m1_cyc_i) begin
                    if (last_gnt_q) begin
                        state_d    = ST_GNT0;
                        last_gnt_d = 1'b0;
                    end else begin
                        state_d    = ST_GNT1;
                        last_gnt_d = 1'b1;
                    end
                end else if (m0_cyc_i) begin
                    state_d    = ST_GNT0;
                    last_gnt_d = 1'b0;
                end else if (m1_cyc_i) begin
                    state_d    = ST_GNT1;
                    last_gnt_d = 1'b1;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_GNT0: begin
                if (!m0_cyc_i) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_GNT0;
                end
            end
            ST_GNT1: begin
                if (!m1_cyc_i) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_GNT1;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                last_gnt_d = 1'b1;
            end
        endcase
    end

    // State and round-robin memory; reset favours master 0 on first contention.
    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            last_gnt_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
        end
    end

    assign gnt0_s      = (state_q == ST_GNT0);
    assign gnt1_s      = (state_q == ST_GNT1);
    assign state_chg_s = (state_d != state_q);

    // Route the granted master's request to the slave; nothing leaks when idle.
    always_comb begin
        stb_raw_s = 1'b0;
        s_we_o    = 1'b0;
        s_adr_o   = {BIST_ADDR_WD{1'b0}};
        s_dat_o   = {BIST_DATA_WD{1'b0}};
        s_sel_o   = {SEL_WD{1'b0}};
        if (gnt0_s) begin
            stb_raw_s = m0_stb_i;
            s_we_o    = m0_we_i;
            s_adr_o   = m0_adr_i;
            s_dat_o   = m0_dat_i;
            s_sel_o   = m0_sel_i;
        end else if (gnt1_s) begin
            stb_raw_s = m1_stb_i;
            s_we_o    = m1_we_i;
            s_adr_o   = m1_adr_i;
            s_dat_o   = m1_dat_i;
            s_sel_o   = m1_sel_i;
        end else begin
            stb_raw_s = 1'b0;
        end
    end

    // The slave must not see a strobe in the cycle the timeout answers it.
    assign s_cyc_o  = gnt0_s | gnt1_s;
    assign s_stb_o  = stb_raw_s & ~tmo_hit_s;

    assign m0_ack_o = gnt0_s & s_ack_i;
    assign m0_err_o = gnt0_s & (s_err_i | tmo_hit_s);
    assign m0_dat_o = gnt0_s ? s_dat_i : {BIST_DATA_WD{1'b0}};
    assign m1_ack_o = gnt1_s & s_ack_i;
    assign m1_err_o = gnt1_s & (s_err_i | tmo_hit_s);
    assign m1_dat_o = gnt1_s ? s_dat_i : {BIST_DATA_WD{1'b0}};

    mbist_wb_tmo #(
        .TMO_CYC   (TMO_CYC)
    ) u_tmo (
        .wb_clk_i  (wb_clk_i),
        .rst_n     (rst_n),
        .stb_i     (stb_raw_s),
        .ack_i     (s_ack_i),
        .err_i     (s_err_i),
        .clr_i     (state_chg_s),
        .tmo_hit_o (tmo_hit_s)
    );

endmodule

// File: tb/tb_mbist_wb_arb.sv
// Randomised and directed bench for mbist_wb_arb against a cycle-level
// ownership model (who owns the bus, who went last, how long the slave stalled).
module tb_mbist_wb_arb;

    localparam int AW  = 10;
    localparam int DW  = 32;
    localparam int SW  = 4;
    localparam int TMO = 16;

    logic          wb_clk_i = 1'b0;
    logic          rst_n;
    logic          bist_en;
    logic          m_cyc [2];
    logic          m_stb [2];
    logic          m_we  [2];
    logic [AW-1:0] m_adr [2];
    logic [DW-1:0] m_dat [2];
    logic [SW-1:0] m_sel [2];
    logic [DW-1:0] s_dat_i;
    logic          s_ack_i;
    logic          s_err_i;

    logic [DW-1:0] m0_dat_o, m1_dat_o, s_dat_o;
    logic          m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
    logic          s_cyc_o, s_stb_o, s_we_o;
    logic [AW-1:0] s_adr_o;
    logic [SW-1:0] s_sel_o;

    int checks = 0;
    int errors = 0;

    // Reference model: owner -1 = nobody, else master index.
    int owner = -1;
    int last  = 1;
    int stall = 0;

    mbist_wb_arb #(.BIST_ADDR_WD(AW), .BIST_DATA_WD(DW), .TMO_CYC(TMO)) dut (
        .wb_clk_i (wb_clk_i), .rst_n (rst_n), .bist_en (bist_en),
        .m0_cyc_i (m_cyc[0]), .m0_stb_i (m_stb[0]), .m0_we_i (m_we[0]),
        .m0_adr_i (m_adr[0]), .m0_dat_i (m_dat[0]), .m0_sel_i (m_sel[0]),
        .m0_dat_o (m0_dat_o), .m0_ack_o (m0_ack_o), .m0_err_o (m0_err_o),
        .m1_cyc_i (m_cyc[1]), .m1_stb_i (m_stb[1]), .m1_we_i (m_we[1]),
        .m1_adr_i (m_adr[1]), .m1_dat_i (m_dat[1]), .m1_sel_i (m_sel[1]),
        .m1_dat_o (m1_dat_o), .m1_ack_o (m1_ack_o), .m1_err_o (m1_err_o),
        .s_cyc_o  (s_cyc_o),  .s_stb_o  (s_stb_o),  .s_we_o   (s_we_o),
        .s_adr_o  (s_adr_o),  .s_dat_o  (s_dat_o),  .s_sel_o  (s_sel_o),
        .s_dat_i  (s_dat_i),  .s_ack_i  (s_ack_i),  .s_err_i  (s_err_i)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic idle_all();
        for (int k = 0; k < 2; k++) begin
            m_cyc[k] = 1'b0; m_stb[k] = 1'b0; m_we[k] = 1'b0;
            m_adr[k] = '0;   m_dat[k] = '0;   m_sel[k] = '0;
        end
        s_ack_i = 1'b0; s_err_i = 1'b0; s_dat_i = '0;
    endtask

    task automatic model_reset();
        owner = -1; last = 1; stall = 0;
    endtask

    // Called just after a falling edge with inputs applied: compare every
    // output against the model, advance the model, wait for the next fall.
    task automatic cycle();
        int  o, g, n;
        logic raw, hit;
        #1;
        o   = owner;
        g   = (o >= 0) ? o : 0;
        raw = (o >= 0) && m_stb[g];
        hit = raw && (stall == TMO - 1) && !s_ack_i;
        check_eq("s_cyc",  s_cyc_o, o >= 0);
        check_eq("s_stb",  s_stb_o, raw && !hit);
        check_eq("s_we",   s_we_o,  (o >= 0) ? m_we[g]  : 1'b0);
        check_eq("s_adr",  s_adr_o, (o >= 0) ? m_adr[g] : 10'h0);
        check_eq("s_dat",  s_dat_o, (o >= 0) ? m_dat[g] : 32'h0);
        check_eq("s_sel",  s_sel_o, (o >= 0) ? m_sel[g] : 4'h0);
        check_eq("m0_ack", m0_ack_o, (o == 0) && s_ack_i);
        check_eq("m0_err", m0_err_o, (o == 0) && (s_err_i || hit));
        check_eq("m0_dat", m0_dat_o, (o == 0) ? s_dat_i : 32'h0);
        check_eq("m1_ack", m1_ack_o, (o == 1) && s_ack_i);
        check_eq("m1_err", m1_err_o, (o == 1) && (s_err_i || hit));
        check_eq("m1_dat", m1_dat_o, (o == 1) ? s_dat_i : 32'h0);
        if (!rst_n) begin
            model_reset();
        end else if (o < 0) begin
            n = -1;
            if (bist_en) begin
                if (m_cyc[1]) n = 1;
            end else if (m_cyc[0] && m_cyc[1]) begin
                n = 1 - last;
            end else if (m_cyc[0]) begin
                n = 0;
            end else if (m_cyc[1]) begin
                n = 1;
            end
            if (n >= 0) last = n;
            owner = n;
            stall = 0;
        end else if (!m_cyc[o]) begin
            owner = -1;
            stall = 0;
        end else if (raw && !hit && !s_ack_i && !s_err_i) begin
            stall++;
        end else begin
            stall = 0;
        end
        @(negedge wb_clk_i);
    endtask

    // mode 1 = hung slave with strobes held, so timeouts actually occur.
    task automatic rand_inputs(input int mode);
        for (int k = 0; k < 2; k++) begin
            if (m_cyc[k]) begin
                if ($urandom_range(0, 15) == 0) m_cyc[k] = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
                m_cyc[k] = 1'b1;
            end
            m_stb[k] = m_cyc[k] && (mode == 1 || $urandom_range(0, 3) != 0);
            m_we[k]  = 1'($urandom_range(0, 1));
            m_adr[k] = AW'($urandom);
            m_dat[k] = $urandom;
            m_sel[k] = SW'($urandom);
        end
        if ($urandom_range(0, 31) == 0) bist_en = ~bist_en;
        s_dat_i = $urandom;
        s_ack_i = (mode != 1) && ($urandom_range(0, 2) == 0);
        s_err_i = (mode != 1) ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 63) == 0);
    endtask

    initial begin
        int n_stb, err_at, ack_acc;
        logic stb_at_err;

        rst_n = 1'b0; bist_en = 1'b0;
        idle_all();
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
        model_reset();
        @(negedge wb_clk_i);
        // Reset state: requests present, everything still zero.
        cycle();
        cycle();

        // Contention right after reset: master 0 first, then master 1.
        idle_all();
        rst_n = 1'b1;
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_adr[0] = 10'h011;
        m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_adr[1] = 10'h022;
        cycle();
        #1 check_eq("cont_first_adr", s_adr_o, 10'h011);
        cycle();
        m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
        cycle();
        #1 check_eq("cont_gap_cyc", s_cyc_o, 1'b0);
        cycle();
        #1 check_eq("cont_second_adr", s_adr_o, 10'h022);
        cycle();
        idle_all();
        cycle();
        cycle();

        // Host write with same-cycle ack.
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_we[0] = 1'b1;
        m_adr[0] = 10'h005; m_dat[0] = 32'hDEADBEEF; m_sel[0] = 4'hF;
        s_ack_i = 1'b1;
        cycle();
        #1;
        check_eq("wr_stb", s_stb_o, 1'b1);
        check_eq("wr_ack", m0_ack_o, 1'b1);
        check_eq("wr_dat", s_dat_o, 32'hDEADBEEF);
        check_eq("wr_m1_ack", m1_ack_o, 1'b0);
        cycle();
        idle_all();
        cycle();
        cycle();

        // BIST read acked in the second strobe cycle.
        bist_en = 1'b1;
        m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_adr[1] = 10'h3FF;
        s_dat_i = 32'hA5A5A5A5;
        cycle();
        cycle();
        s_ack_i = 1'b1;
        #1;
        check_eq("rd_ack", m1_ack_o, 1'b1);
        check_eq("rd_dat", m1_dat_o, 32'hA5A5A5A5);
        check_eq("rd_m0_dat", m0_dat_o, 32'h0);
        cycle();
        idle_all();
        cycle();
        cycle();

        // bist_en with both requesting: host never served.
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
        m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
        s_ack_i = 1'b1;
        ack_acc = 0;
        for (int i = 0; i < 20; i++) begin
            #1 ack_acc += int'(m0_ack_o);
            cycle();
        end
        check_eq("bist_excl_m0_acks", ack_acc, 0);
        idle_all();
        bist_en = 1'b0;
        cycle();
        cycle();

        // Timeout: hung slave, error on the 16th strobe cycle, then again.
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
        n_stb = 0; err_at = 0; stb_at_err = 1'b1;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (s_cyc_o && err_at == 0) n_stb++;
            if (m0_err_o && err_at == 0) begin
                err_at     = n_stb;
                stb_at_err = s_stb_o;
            end
            cycle();
        end
        check_eq("tmo_err_cycle", err_at, TMO);
        check_eq("tmo_stb_masked", stb_at_err, 1'b0);
        idle_all();
        cycle();
        cycle();

        // Ack on the threshold cycle beats the timeout.
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
        cycle();
        for (int i = 0; i < TMO - 1; i++) cycle();
        s_ack_i = 1'b1;
        #1;
        check_eq("ack_wins_err", m0_err_o, 1'b0);
        check_eq("ack_wins_ack", m0_ack_o, 1'b1);
        cycle();
        idle_all();
        cycle();
        cycle();

        // Reset in the middle of a BIST strobe.
        bist_en = 1'b1;
        m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_adr[1] = 10'h155;
        cycle();
        cycle();
        cycle();
        rst_n = 1'b0;
        model_reset();
        #1 check_eq("rst_mid_stb", s_stb_o, 1'b0);
        check_eq("rst_mid_cyc", s_cyc_o, 1'b0);
        cycle();
        rst_n = 1'b1;
        cycle();
        #1 check_eq("rst_rearb_stb", s_stb_o, 1'b1);
        cycle();
        idle_all();
        bist_en = 1'b0;
        cycle();

        // Randomised traffic through all modes.
        for (int i = 0; i < 3000; i++) begin
            rand_inputs((i / 200) % 3);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mbist_wb_arb.md
Name: mbist_wb_arb

Overview:
- Two-master Wishbone arbiter feeding the single WB slave port of the MBIST memory wrapper.
- Master 0 is the functional host; master 1 is the MBIST controller.
- Grants are registered and locked for the whole cyc; bist_en forces exclusive BIST access.
- A per-access timeout converts a hung slave into a one-cycle error back to the requesting master.

Parameters:
- BIST_ADDR_WD, 10, address width, same as the memory wrapper.
- BIST_DATA_WD, 32, data width; must be a multiple of 8.
- TMO_CYC, 16, number of stb cycles without ack/err before a timeout error; must be >= 2.

Ports:
- wb_clk_i  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- bist_en  in  1  1 = only master 1 may be granted
- m0_cyc_i, m0_stb_i, m0_we_i  in  1 each  host WB control
- m0_adr_i  in  BIST_ADDR_WD  host address
- m0_dat_i  in  BIST_DATA_WD  host write data
- m0_sel_i  in  BIST_DATA_WD/8  host byte enables
- m0_dat_o  out  BIST_DATA_WD  host read data
- m0_ack_o, m0_err_o  out  1 each  host ack / error
- m1_* (cyc, stb, we, adr, dat, sel in; dat_o, ack_o, err_o out)  same widths  BIST master
- s_cyc_o, s_stb_o, s_we_o  out  1 each  slave control
- s_adr_o  out  BIST_ADDR_WD  slave address
- s_dat_o  out  BIST_DATA_WD  slave write data
- s_sel_o  out  BIST_DATA_WD/8  slave byte enables
- s_dat_i  in  BIST_DATA_WD  slave read data
- s_ack_i, s_err_i  in  1 each  slave ack / error

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, last_gnt=1, tmo_cnt=0.
  - All outputs 0.
  - Reset mid-transfer drops s_stb_o the same instant; no ack or err is produced.
- FSM states: IDLE, GNT0, GNT1 (registered).
- IDLE arbitration, evaluated on m*_cyc_i:
  - bist_en=1: m1_cyc -> GNT1; m0 is ignored.
  - bist_en=0, one requester: grant it.
  - bist_en=0, both request: round-robin, grant != last_gnt.
  - On each grant, last_gnt is updated.
- Latency: request sampled in IDLE at edge N; s_stb_o first asserted in cycle N+1. One idle cycle of arbitration overhead per cyc.
- GNTx forwarding:
  - s_cyc_o=1.
  - s_stb/we/adr/dat/sel = mx_* combinationally.
  - mx_ack_o = s_ack_i; mx_err_o = s_err_i | tmo_hit.
  - mx_dat_o = s_dat_i.
  - Non-granted master: ack, err and dat_o all 0.
- GNTx -> IDLE when mx_cyc_i=0 (bus lock held across multiple stb phases).
- bist_en rising while in GNT0: host is not aborted. After the host cyc drops, the next grant goes only to m1.
- Timeout:
  - tmo_cnt increments each cycle s_stb_o=1 & !s_ack_i & !s_err_i.
  - tmo_cnt clears on ack, err, !stb, or state change.
  - tmo_hit when tmo_cnt == TMO_CYC-1 & s_stb_o & !s_ack_i: err pulses for one cycle, then tmo_cnt clears.
  - s_stb_o is masked during the tmo_hit cycle. Grant is held until cyc drops.
- Simultaneous s_ack_i and tmo threshold: ack wins, no err.
- Simultaneous s_ack_i and s_err_i: both forwarded unchanged.
- Master dropping stb mid-wait (no ack yet): s_stb_o follows, tmo_cnt clears, no err.

Decomposition:
- Package mbist_pkg holds:
  - the arbiter state enum (IDLE/GNT0/GNT1);
  - a wb_req_t struct {cyc, stb, we, adr, dat, sel}, parameterised through localparams of BIST_ADDR_WD/BIST_DATA_WD defaults;
  - the TMO_CYC default constant.
- One sub-module: mbist_wb_tmo (timeout counter and tmo_hit generation), instantiated once.

Test Plan:
- Host write, bist_en=0: m0 cyc/stb/we=1, adr=0x05, dat=0xDEADBEEF, sel=0xF, slave acks same cycle -> s_stb_o in cycle 2, m0_ack_o=1 in cycle 2, m1 outputs 0.
- BIST read with one-cycle ack: m1 read adr=0x3FF, s_dat_i=0xA5A5A5A5 with ack in the 2nd stb cycle -> m1_dat_o=0xA5A5A5A5 when m1_ack_o=1; m0_dat_o=0.
- Contention: both cyc rise together after reset -> GNT0 first (last_gnt=1). After m0 cyc drops -> IDLE one cycle, then GNT1.
- bist_en=1 with both requesting -> only m1 granted; m0 stays waiting with ack=0 for 20 cycles.
- Timeout: m0 stb held, slave never acks, TMO_CYC=16 -> m0_err_o=1 exactly in the 16th stb cycle, s_stb_o=0 that cycle; counter restarts after.
- Reset mid-op: rst_n=0 during GNT1 stb -> all outputs 0 immediately. After release, state=IDLE and re-arbitration takes one cycle.
